// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I multi-cycle core: sequencer states,
// execute-phase encodings and architectural reset constants.
// No logic beyond a pure state-to-phase decode helper.
package rv32i_pkg;

  // Sequencer states; TRAP is terminal until reset.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } seq_state_e;

  // Phase values presented to the execute decoder on its t input.
  localparam logic [1:0] T_FETCH  = 2'd0;
  localparam logic [1:0] T_DECODE = 2'd1;
  localparam logic [1:0] T_EXEC   = 2'd2;
  localparam logic [1:0] T_WB     = 2'd3;

  // addi x0, x0, 0 -- harmless filler for the instruction register.
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // Default program counter after reset.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // MEM shares the EXEC phase so the datapath keeps driving the address;
  // TRAP reports FETCH so execute sees an idle phase.
  function automatic logic [1:0] phase_of(input seq_state_e s);
    logic [1:0] p;
    p = T_FETCH;
    case (s)
      ST_DECODE:       p = T_DECODE;
      ST_EXEC, ST_MEM: p = T_EXEC;
      ST_WB:           p = T_WB;
      default:         p = T_FETCH;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/rv32i_pc_unit.sv
// Program counter: holds the PC, computes PC+4 or the word-aligned jump target.
// Latency: new PC visible the cycle after commit_i; misalign_o is combinational.
// Backpressure: none; the PC only moves when the sequencer commits.
module rv32i_pc_unit
  import rv32i_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            commit_i,
  input  logic            jump_i,
  input  logic [XLEN-1:0] alu_y_i,
  output logic [XLEN-1:0] pc_o,
  output logic            misalign_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] jump_target;

  // Sequential fall-through wraps naturally at 2^XLEN.
  assign pc_plus4    = pc_q + XLEN'(4);
  // Low bits are dropped so the PC is always word aligned.
  assign jump_target = {alu_y_i[XLEN-1:2], 2'b00};
  // Only a taken jump can be misaligned; fall-through is always aligned.
  assign misalign_o  = jump_i & (alu_y_i[1:0] != 2'b00);

  // Select the next PC; hold unless the sequencer commits a retirement.
  always_comb begin
    pc_d = pc_q;
    if (commit_i) begin
      pc_d = jump_i ? jump_target : pc_plus4;
    end
  end

  // PC register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/rv32i_sequencer.sv
// Multi-cycle RV32I control sequencer: fetch, phase stepping, PC/IR/instret commit.
// Latency: 4 cycles per ALU instruction, 5 plus data wait states for loads/stores.
// Backpressure: FETCH holds for imem_ack, MEM holds for dmem_ack; requests are state-decoded.
// Option: RV32I_SEQ_MISALIGN_TRAP_EN traps on a taken jump to a non-word-aligned target.
module rv32i_sequencer
  import rv32i_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter logic [31:0]     NOP      = NOP_INSN
) (
  input  logic            clk,
  input  logic            rst_n,
  // instruction fetch port
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  // execute decoder interface
  output logic [31:0]     inst,
  output logic [1:0]      t,
  input  logic            exc,
  input  logic            jump,
  input  logic            is_mem,
  input  logic            wb_en,
  input  logic [XLEN-1:0] alu_y,
  // data memory handshake
  output logic            dmem_req,
  input  logic            dmem_ack,
  // architectural state
  output logic            rf_we,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instret,
  output logic            halt
);

  seq_state_e      state_q;
  seq_state_e      state_d;
  logic [31:0]     inst_q;
  logic [31:0]     inst_d;
  logic [XLEN-1:0] instret_q;
  logic [XLEN-1:0] instret_d;

  logic            pc_commit;
  logic            pc_misalign;
  logic            wb_trap;

  // A misaligned taken jump becomes a trap only when the option is built in;
  // otherwise the PC unit silently word-aligns the target.
`ifdef RV32I_SEQ_MISALIGN_TRAP_EN
  assign wb_trap = pc_misalign;
`else
  logic unused_misalign;
  assign unused_misalign = pc_misalign;
  assign wb_trap         = 1'b0;
`endif

  rv32i_pc_unit #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .commit_i   (pc_commit),
    .jump_i     (jump),
    .alu_y_i    (alu_y),
    .pc_o       (pc),
    .misalign_o (pc_misalign)
  );

  // Next-state and output decode; inputs are only looked at in the state that owns them.
  always_comb begin
    state_d   = state_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    rf_we     = 1'b0;
    halt      = 1'b0;
    pc_commit = 1'b0;
    t         = phase_of(state_q);

    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = exc ? ST_TRAP : ST_EXEC;
      end
      ST_EXEC: begin
        state_d = is_mem ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        // A trapping jump must leave no architectural trace.
        rf_we     = wb_en & ~wb_trap;
        pc_commit = ~wb_trap;
        state_d   = wb_trap ? ST_TRAP : ST_FETCH;
      end
      ST_TRAP: begin
        halt    = 1'b1;
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Instruction register: capture on fetch ack, scrub to NOP once trapped.
  always_comb begin
    inst_d = inst_q;
    if (state_q == ST_FETCH && imem_ack) begin
      inst_d = imem_rdata;
    end else if (state_q == ST_TRAP) begin
      inst_d = NOP;
    end
  end

  // Retired-instruction counter advances exactly when the PC commits.
  always_comb begin
    instret_d = instret_q;
    if (pc_commit) begin
      instret_d = instret_q + XLEN'(1);
    end
  end

  // State, IR and instret registers; reset wins over every state including TRAP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      inst_q    <= NOP;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      instret_q <= instret_d;
    end
  end

  assign imem_addr = pc;
  assign inst      = inst_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_rv32i_sequencer.sv
// Directed bench for rv32i_sequencer with a scoreboard of expected retirements.
// Each instruction pushes its expected commit; the WB step pops and compares.
// Honours RV32I_SEQ_MISALIGN_TRAP_EN for the misaligned-jump expectations.
module tb_rv32i_sequencer;
  import rv32i_pkg::*;

  localparam logic [31:0] I_ADDI = 32'h0010_0093;
  localparam logic [31:0] I_LW   = 32'h0000_a103;
  localparam logic [31:0] I_SW   = 32'h0020_a023;
  localparam logic [31:0] I_JAL  = 32'h0000_006f;
  localparam logic [31:0] I_BAD  = 32'hffff_ffff;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [1:0]  t;
  logic        exc;
  logic        jump;
  logic        is_mem;
  logic        wb_en;
  logic [31:0] alu_y;
  logic        dmem_req;
  logic        dmem_ack;
  logic        rf_we;
  logic [31:0] pc;
  logic [31:0] instret;
  logic        halt;

  rv32i_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .t          (t),
    .exc        (exc),
    .jump       (jump),
    .is_mem     (is_mem),
    .wb_en      (wb_en),
    .alu_y      (alu_y),
    .dmem_req   (dmem_req),
    .dmem_ack   (dmem_ack),
    .rf_we      (rf_we),
    .pc         (pc),
    .instret    (instret),
    .halt       (halt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc_after;
    logic        rf_we;
    logic [31:0] instret_after;
    logic        halt;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_pc;
  logic [31:0] m_instret;
  logic        stray = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    exc        = 1'b0;
    jump       = 1'b0;
    is_mem     = 1'b0;
    wb_en      = 1'b0;
    alu_y      = 32'h0;
    imem_ack   = stray;
    dmem_ack   = stray;
    imem_rdata = 32'hdead_beef;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_pc",       pc,                32'h0);
    chk("rst_inst",     inst,              NOP_INSN);
    chk("rst_t",        32'(t),            32'd0);
    chk("rst_instret",  instret,           32'h0);
    chk("rst_halt",     32'(halt),         32'd0);
    chk("rst_rf_we",    32'(rf_we),        32'd0);
    chk("rst_dmem_req", 32'(dmem_req),     32'd0);
    chk("rst_imem_req", 32'(imem_req),     32'd1);
    m_pc      = 32'h0;
    m_instret = 32'h0;
    sb_q.delete();
  endtask

  task automatic check_commit(input string tag, input exp_t e);
    chk({tag, "_pc"},      pc,          e.pc_after);
    chk({tag, "_instret"}, instret,     e.instret_after);
    chk({tag, "_halt"},    32'(halt),   32'(e.halt));
    chk({tag, "_rf_we"},   32'(rf_we),  32'd0);
    chk({tag, "_t"},       32'(t),      32'd0);
    chk({tag, "_ireq"},    32'(imem_req), 32'(!e.halt));
    m_pc      = e.pc_after;
    m_instret = e.instret_after;
  endtask

  // Drive one instruction through every phase; exp is pushed at issue, popped at commit.
  task automatic run_insn(input logic [31:0] ins, input int iwait, input logic ex,
                          input logic mem, input int dwait, input logic wb,
                          input logic jmp, input logic [31:0] y);
    exp_t e;
    logic mis_trap;
`ifdef RV32I_SEQ_MISALIGN_TRAP_EN
    mis_trap = jmp && (y[1:0] != 2'b00);
`else
    mis_trap = 1'b0;
`endif
    if (ex || mis_trap) begin
      e.pc_after = m_pc; e.rf_we = 1'b0; e.instret_after = m_instret; e.halt = 1'b1;
    end else begin
      e.pc_after = jmp ? {y[31:2], 2'b00} : m_pc + 32'd4;
      e.rf_we = wb; e.instret_after = m_instret + 32'd1; e.halt = 1'b0;
    end
    sb_q.push_back(e);

    // FETCH
    imem_rdata = ins;
    imem_ack   = 1'b0;
    for (int i = 0; i < iwait; i++) begin
      chk("fetch_wait_req",  32'(imem_req), 32'd1);
      chk("fetch_wait_addr", imem_addr,     m_pc);
      chk("fetch_wait_t",    32'(t),        32'd0);
      tick();
    end
    imem_ack = 1'b1;
    chk("fetch_req",  32'(imem_req), 32'd1);
    chk("fetch_addr", imem_addr,     m_pc);
    tick();
    imem_ack   = stray;
    imem_rdata = 32'hdead_beef;

    // DECODE
    chk("decode_t",    32'(t),        32'd1);
    chk("decode_inst", inst,          ins);
    chk("decode_ireq", 32'(imem_req), 32'd0);
    exc = ex;
    tick();
    exc = 1'b0;
    if (ex) begin
      e = sb_q.pop_front();
      check_commit("trap", e);
      return;
    end

    // EXEC
    chk("exec_t",     32'(t),        32'd2);
    chk("exec_inst",  inst,          ins);
    chk("exec_dreq",  32'(dmem_req), 32'd0);
    chk("exec_rf_we", 32'(rf_we),    32'd0);
    is_mem = mem;
    tick();
    is_mem = 1'b0;

    // MEM
    if (mem) begin
      dmem_ack = 1'b0;
      for (int i = 0; i < dwait; i++) begin
        chk("mem_wait_dreq", 32'(dmem_req), 32'd1);
        chk("mem_wait_t",    32'(t),        32'd2);
        tick();
      end
      dmem_ack = 1'b1;
      chk("mem_dreq", 32'(dmem_req), 32'd1);
      tick();
      dmem_ack = stray;
    end

    // WB
    chk("wb_t",    32'(t),        32'd3);
    chk("wb_dreq", 32'(dmem_req), 32'd0);
    wb_en = wb; jump = jmp; alu_y = y;
    #1;
    e = sb_q.pop_front();
    chk("wb_rf_we",   32'(rf_we), 32'(e.rf_we));
    chk("wb_pc_hold", pc,         m_pc);
    tick();
    wb_en = 1'b0; jump = 1'b0; alu_y = 32'h0;
    check_commit("commit", e);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    do_reset();

    // Back-to-back ADDIs with acks held high: ack-in-first-cycle, stray acks ignored.
    stray = 1'b1;
    idle_inputs();
    for (int k = 0; k < 3; k++) run_insn(I_ADDI, 0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 32'h0);
    chk("addi_instret3", instret, 32'd3);
    chk("addi_pc12",     pc,      32'h0000_000c);
    stray = 1'b0;
    idle_inputs();

    // Fetch ack delayed three cycles.
    run_insn(I_ADDI, 3, 1'b0, 1'b0, 0, 1'b1, 1'b0, 32'h0);
    // Load waiting two cycles for data, then a zero-wait store without writeback.
    run_insn(I_LW, 0, 1'b0, 1'b1, 2, 1'b1, 1'b0, 32'h0);
    run_insn(I_SW, 0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 32'h0);
    // Aligned taken jump.
    run_insn(I_JAL, 0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 32'h0000_0040);
    chk("jmp_aligned_pc", pc, 32'h0000_0040);
    // Misaligned taken jump: aligned fall-back, or trap with the option built in.
    run_insn(I_JAL, 1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 32'h0000_0102);
`ifdef RV32I_SEQ_MISALIGN_TRAP_EN
    chk("jmp_mis_pc",   pc,        32'h0000_0040);
    chk("jmp_mis_halt", 32'(halt), 32'd1);
`else
    chk("jmp_mis_pc",   pc,        32'h0000_0100);
    chk("jmp_mis_halt", 32'(halt), 32'd0);
`endif

    // Invalid instruction at pc 0x10 traps and stays trapped.
    do_reset();
    for (int k = 0; k < 4; k++) run_insn(I_ADDI, 0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 32'h0);
    run_insn(I_BAD, 0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 32'h0);
    stray = 1'b1;
    idle_inputs();
    wb_en = 1'b1; jump = 1'b1; alu_y = 32'h0000_0200;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("trap_halt",    32'(halt),     32'd1);
      chk("trap_pc",      pc,            32'h0000_0010);
      chk("trap_instret", instret,       32'd4);
      chk("trap_inst",    inst,          NOP_INSN);
      chk("trap_ireq",    32'(imem_req), 32'd0);
      chk("trap_dreq",    32'(dmem_req), 32'd0);
      chk("trap_rf_we",   32'(rf_we),    32'd0);
    end
    stray = 1'b0;
    do_reset();
    chk("trap_cleared_halt", 32'(halt), 32'd0);

    // Retiring with instret at all-ones wraps to zero.
    force dut.instret_q = 32'hffff_ffff;
    #1;
    release dut.instret_q;
    m_instret = 32'hffff_ffff;
    chk("preload_instret", instret, 32'hffff_ffff);
    run_insn(I_ADDI, 0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 32'h0);
    chk("wrap_instret", instret, 32'h0);

    // Reset while waiting in MEM with instret at all-ones.
    force dut.instret_q = 32'hffff_ffff;
    #1;
    release dut.instret_q;
    imem_rdata = I_LW; imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();
    is_mem = 1'b1;
    tick();
    is_mem = 1'b0;
    chk("abort_in_mem_dreq", 32'(dmem_req), 32'd1);
    tick();
    chk("abort_still_dreq", 32'(dmem_req), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("abort_dreq_drop", 32'(dmem_req), 32'd0);
    dmem_ack = 1'b1;
    tick();
    rst_n = 1'b1;
    chk("abort_instret", instret,       32'h0);
    chk("abort_pc",      pc,            32'h0);
    chk("abort_dreq",    32'(dmem_req), 32'd0);
    chk("abort_ireq",    32'(imem_req), 32'd1);
    tick();
    dmem_ack = 1'b0;
    chk("late_ack_t",    32'(t),        32'd0);
    chk("late_ack_dreq", 32'(dmem_req), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
